fft_reorder: RTL and testbench
==============================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning the number of parallel samples per beat.
REQ-002 SHALL have parameter WIDTH, default 13, meaning the signed sample width of each real and imaginary part.
REQ-003 SHALL have parameter NPOINT, default 512, meaning the FFT frame length; beats per frame = NPOINT/LANES (32).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-006 SHALL have port din_valid, input, 1, input beat valid; driven by the FFT core's output_en.
REQ-007 SHALL have ports din_re / din_im, input, LANES x WIDTH signed each, one beat of bit-reversed FFT output.
REQ-008 SHALL have port din_ready, output, 1, asserted when a beat can be accepted.
REQ-009 SHALL have port dout_valid, output, 1, output beat valid.
REQ-010 SHALL have port dout_ready, input, 1, downstream accepts the beat.
REQ-011 SHALL have ports dout_re / dout_im, output, LANES x WIDTH signed each, one beat of natural-order bins.
REQ-012 SHALL have port dout_last, output, 1, marks the final beat (index 31) of a frame.
REQ-013 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-014 Input transfer SHALL occur when din_valid && din_ready; output transfer SHALL occur when dout_valid && dout_ready.
REQ-015 Input beat c (0..31), lane m SHALL carry bin k = bitrev9(16*c + m); the sample SHALL be stored at address k.
REQ-016 Output beat c (0..31), lane m SHALL carry bin 16*c + m.
REQ-017 Data SHALL pass unmodified: no scaling, rounding or width change.
REQ-018 Storage SHALL be two ping-pong banks of NPOINT complex entries; the write bank and read bank SHALL toggle independently.
REQ-019 The write side SHALL keep a beat counter wcnt (0..31) and a write-bank pointer; on the beat with wcnt==31 the bank SHALL be marked full, wcnt SHALL wrap to 0 and the pointer SHALL toggle.
REQ-020 din_ready SHALL be 1 exactly when the current write bank is not full.
REQ-021 The read side SHALL be an FSM with states IDLE and READ.
REQ-022 IDLE -> READ SHALL happen on the cycle after the read bank becomes full; dout_valid SHALL be 1 throughout READ.
REQ-023 The first output beat SHALL be valid 1 cycle after the accepting edge of input beat 31 (latency 1 cycle when the read bank is free).
REQ-024 The read side SHALL keep a beat counter rcnt; rcnt SHALL advance only on an output transfer.
REQ-025 While dout_ready=0, the dout_* outputs SHALL hold stable.
REQ-026 On an output transfer with rcnt==31, the read bank SHALL be marked empty, the read pointer SHALL toggle, and the FSM SHALL go to READ if the other bank is full, else to IDLE.
REQ-027 dout_last SHALL be 1 only when dout_valid=1 and rcnt==31.
REQ-028 If a bank is freed and the other bank completes on the same cycle, both events SHALL take effect; no beat SHALL be lost or duplicated.
REQ-029 If din_valid=1 while din_ready=0, the beat SHALL be dropped and overflow SHALL set to 1 and stay at 1 until reset.
REQ-030 A frame interrupted mid-way SHALL only be discarded by rst; there SHALL be no partial-frame output.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL apply: wcnt=0, rcnt=0, both banks empty, both pointers at bank 0, FSM=IDLE.
REQ-032 The same reset SHALL apply: dout_valid=0, dout_last=0, dout_re/dout_im all 0, din_ready=1, overflow=0.
REQ-033 Bank memory contents SHALL NOT require a reset.
REQ-034 Reset asserted mid-frame or mid-readout SHALL abandon all stored data.
REQ-035 The first beat accepted after reset SHALL be treated as beat 0.

Verification
REQ-036 Ramp test: drive lane m of beat c with re=bitrev9(16c+m), im=-re, dout_ready=1 -> output beat c lane m shows re=16c+m, im=-(16c+m); first dout_valid 1 cycle after input beat 31; dout_last on beat 31.
REQ-037 Back-to-back frames: two 32-beat frames with din_valid held at 1 and dout_ready=1 -> din_ready stays 1; outputs continuous for 64 beats; the second frame is correctly ordered.
REQ-038 Backpressure: dout_ready=0 for 40 cycles during readout while frames 2 and 3 arrive -> din_ready drops after frame 2 fills; dout holds stable; no overflow if the source obeys din_ready.
REQ-039 Overflow: same as REQ-038 but din_valid is forced high ignoring din_ready -> overflow=1 from the first dropped beat and stays 1; frames already stored are still output intact.
REQ-040 Reset mid-frame: rst pulsed after input beat 17 -> all outputs match their reset values next cycle; a fresh full frame then reorders correctly.
REQ-041 Random data: 9-bit-derived random frames compared against a software bit-reverse model -> zero mismatches over 8 frames with random dout_ready.

Source files
------------

// File: rtl/fft_reorder.sv
// Reorders bit-reversed FFT output beats into natural-order beats through two
// ping-pong banks; the write side and the read side advance independently.
module fft_reorder #(
    parameter int LANES  = 16,
    parameter int WIDTH  = 13,
    parameter int NPOINT = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din_re [LANES],
    input  logic signed [WIDTH-1:0] din_im [LANES],
    output logic                    din_ready,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic signed [WIDTH-1:0] dout_re [LANES],
    output logic signed [WIDTH-1:0] dout_im [LANES],
    output logic                    dout_last,
    output logic                    overflow
);
    localparam int ABITS = $clog2(NPOINT);
    localparam int LBITS = $clog2(LANES);
    localparam int BBITS = ABITS - LBITS;
    localparam logic [BBITS-1:0] LAST_BEAT = BBITS'(NPOINT / LANES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic logic [ABITS-1:0] bitrev(input logic [ABITS-1:0] a);
        logic [ABITS-1:0] r;
        for (int i = 0; i < ABITS; i++) begin
            r[i] = a[ABITS-1-i];
        end
        return r;
    endfunction

    logic signed [WIDTH-1:0] bank_re_q [2][NPOINT];
    logic signed [WIDTH-1:0] bank_im_q [2][NPOINT];

    state_t           state_q, state_d;
    logic [BBITS-1:0] wcnt_q, wcnt_d;
    logic [BBITS-1:0] rcnt_q, rcnt_d;
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       full_q, full_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             overflow_q, overflow_d;
    logic signed [WIDTH-1:0] dout_re_q [LANES];
    logic signed [WIDTH-1:0] dout_re_d [LANES];
    logic signed [WIDTH-1:0] dout_im_q [LANES];
    logic signed [WIDTH-1:0] dout_im_d [LANES];

    logic             wr_en;
    logic             load;
    logic             load_bank;
    logic [BBITS-1:0] load_beat;

    assign din_ready  = ~full_q[wptr_q];
    assign wr_en      = din_valid & din_ready;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign dout_re    = dout_re_q;
    assign dout_im    = dout_im_q;
    assign overflow   = overflow_q;

    // Address a is always fed by the same (beat, lane) pair, namely bitrev(a),
    // so every entry has a fixed source lane and a fixed write beat.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar a = 0; a < NPOINT; a++) begin : g_addr
            localparam logic [ABITS-1:0] SRC = bitrev(ABITS'(a));
            always_ff @(posedge clk) begin
                if (wr_en && (wptr_q == 1'(b)) && (wcnt_q == SRC[ABITS-1:LBITS])) begin
                    bank_re_q[b][a] <= din_re[SRC[LBITS-1:0]];
                    bank_im_q[b][a] <= din_im[SRC[LBITS-1:0]];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        full_d       = full_q;
        dout_re_d    = dout_re_q;
        dout_im_d    = dout_im_q;
        overflow_d   = overflow_q | (din_valid & ~din_ready);
        load         = 1'b0;
        load_bank    = rptr_q;
        load_beat    = rcnt_q;

        if (wr_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == LAST_BEAT) begin
                full_d[wptr_q] = 1'b1;
                wptr_d         = ~wptr_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (full_q[rptr_q]) begin
                    state_d   = READ;
                    rcnt_d    = '0;
                    load      = 1'b1;
                    load_bank = rptr_q;
                    load_beat = '0;
                end
            end
            READ: begin
                if (dout_ready) begin
                    if (rcnt_q == LAST_BEAT) begin
                        full_d[rptr_q] = 1'b0;
                        rptr_d         = ~rptr_q;
                        rcnt_d         = '0;
                        if (full_q[~rptr_q]) begin
                            load      = 1'b1;
                            load_bank = ~rptr_q;
                            load_beat = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rcnt_d    = rcnt_q + 1'b1;
                        load      = 1'b1;
                        load_beat = rcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Output registers only change on a load, so they hold while stalled.
        if (load) begin
            for (int m = 0; m < LANES; m++) begin
                dout_re_d[m] = bank_re_q[load_bank][{load_beat, LBITS'(m)}];
                dout_im_d[m] = bank_im_q[load_bank][{load_beat, LBITS'(m)}];
            end
        end

        dout_valid_d = (state_d == READ);
        dout_last_d  = (state_d == READ) && (rcnt_d == LAST_BEAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
            full_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            overflow_q   <= 1'b0;
            dout_re_q    <= '{default: '0};
            dout_im_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            full_q       <= full_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            overflow_q   <= overflow_d;
            dout_re_q    <= dout_re_d;
            dout_im_q    <= dout_im_d;
        end
    end

endmodule

// File: tb/tb_fft_reorder.sv
// Directed and random-frame bench for fft_reorder: ramp, back-to-back,
// backpressure, overflow, mid-frame reset and random data with random ready.
module tb_fft_reorder;
    localparam int LANES  = 16;
    localparam int WIDTH  = 13;
    localparam int NPOINT = 512;
    localparam int BEATS  = NPOINT / LANES;
    localparam int NFID   = 19;

    logic clk = 1'b0;
    logic rst, din_valid, din_ready, dout_valid, dout_ready, dout_last, overflow;
    logic signed [WIDTH-1:0] din_re [LANES];
    logic signed [WIDTH-1:0] din_im [LANES];
    logic signed [WIDTH-1:0] dout_re [LANES];
    logic signed [WIDTH-1:0] dout_im [LANES];

    fft_reorder #(.LANES(LANES), .WIDTH(WIDTH), .NPOINT(NPOINT)) dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_re(din_re), .din_im(din_im), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_re(dout_re), .dout_im(dout_im),
        .dout_last(dout_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rnd_re [NFID][NPOINT];
    int rnd_im [NFID][NPOINT];
    int exp_q [$];
    int out_beat   = 0;
    int frames_out = 0;
    int cyc        = 0;
    int t_first [NFID];
    int t_last  [NFID];
    int stalls     = 0;
    bit mon_en     = 1'b0;
    bit ovf_first  = 1'b0;
    bit rnd_done   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int bitrev9(input int x);
        int r = 0;
        for (int i = 0; i < 9; i++) r |= ((x >> i) & 1) << (8 - i);
        return r;
    endfunction

    // Frame 0 is the ramp; other frames take bin values from random tables.
    function automatic logic signed [WIDTH-1:0] sre(input int fid, input int k);
        return (fid == 0) ? WIDTH'(k) : WIDTH'(rnd_re[fid][k]);
    endfunction

    function automatic logic signed [WIDTH-1:0] sim(input int fid, input int k);
        return (fid == 0) ? WIDTH'(-k) : WIDTH'(rnd_im[fid][k]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int fid;
        int k;
        if (mon_en && !rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                fid = exp_q[0];
                for (int m = 0; m < LANES; m++) begin
                    k = out_beat * LANES + m;
                    chk("lane_data", {dout_re[m], dout_im[m]}, {sre(fid, k), sim(fid, k)});
                end
                chk("dout_last", dout_last, out_beat == BEATS - 1);
                if (out_beat == 0) t_first[fid] = cyc;
                if (out_beat == BEATS - 1) begin
                    t_last[fid] = cyc;
                    void'(exp_q.pop_front());
                    out_beat = 0;
                    frames_out++;
                end else begin
                    out_beat++;
                end
            end
        end
    end

    task automatic send_frame(input int fid, input int nbeats, input bit obey);
        for (int c = 0; c < nbeats; c++) begin
            int  guard = 0;
            bit  acc;
            bit  drop;
            for (int m = 0; m < LANES; m++) begin
                int k = bitrev9(c * LANES + m);
                din_re[m] = sre(fid, k);
                din_im[m] = sim(fid, k);
            end
            do begin
                acc       = din_ready;
                drop      = !acc && !obey && !ovf_first;
                din_valid = obey ? din_ready : 1'b1;
                if (!acc) stalls++;
                step();
                if (drop) begin
                    ovf_first = 1'b1;
                    chk("overflow_set", overflow, 1'b1);
                end
                guard++;
            end while (!acc && guard < 500);
            if (!acc) chk("send_timeout", 32'd0, 32'd1);
        end
        if (nbeats == BEATS) exp_q.push_back(fid);
    endtask

    task automatic wait_frames(input int n, input int max_cyc);
        int g = 0;
        while (frames_out < n && g < max_cyc) begin
            step();
            g++;
        end
        chk("frames_out", frames_out, n);
    endtask

    task automatic stall_window(input string tag);
        int g = 0;
        int changed = 0;
        bit saw_nr = 1'b0;
        logic signed [WIDTH-1:0] s_re [LANES];
        logic signed [WIDTH-1:0] s_im [LANES];
        logic s_valid, s_last;
        while (!dout_valid && g < 300) begin
            step();
            g++;
        end
        chk({tag, "_readout_start"}, dout_valid, 1'b1);
        repeat (3) step();
        dout_ready = 1'b0;
        s_re = dout_re;
        s_im = dout_im;
        s_valid = dout_valid;
        s_last  = dout_last;
        repeat (40) begin
            step();
            for (int m = 0; m < LANES; m++)
                if (dout_re[m] !== s_re[m] || dout_im[m] !== s_im[m]) changed++;
            if (dout_valid !== s_valid || dout_last !== s_last) changed++;
            if (!din_ready) saw_nr = 1'b1;
        end
        chk({tag, "_hold_stable"}, changed, 32'd0);
        chk({tag, "_din_ready_drop"}, saw_nr, 1'b1);
        dout_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        for (int m = 0; m < LANES; m++) begin
            din_re[m] = '0;
            din_im[m] = '0;
        end
        for (int f = 0; f < NFID; f++) begin
            t_first[f] = 0;
            t_last[f]  = 0;
            for (int k = 0; k < NPOINT; k++) begin
                rnd_re[f][k] = int'($urandom_range(0, 8191));
                rnd_im[f][k] = int'($urandom_range(0, 8191));
            end
        end

        repeat (2) step();
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_dout_last", dout_last, 1'b0);
        chk("rst_din_ready", din_ready, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_dout_re0", dout_re[0], 32'd0);
        chk("rst_dout_im15", dout_im[LANES-1], 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Ramp frame and first-output latency
        dout_ready = 1'b1;
        send_frame(0, BEATS, 1'b1);
        din_valid = 1'b0;
        chk("latency_not_yet", dout_valid, 1'b0);
        step();
        chk("latency_valid", dout_valid, 1'b1);
        chk("ramp_b0_l5_re", dout_re[5], 32'd5);
        chk("ramp_b0_l5_im", dout_im[5], -32'sd5);
        chk("ramp_b0_last", dout_last, 1'b0);
        wait_frames(1, 100);

        // Back-to-back frames
        stalls = 0;
        send_frame(1, BEATS, 1'b1);
        send_frame(2, BEATS, 1'b1);
        din_valid = 1'b0;
        chk("b2b_no_stall", stalls, 32'd0);
        wait_frames(3, 200);
        chk("b2b_continuous", t_last[2] - t_first[1], 32'd63);

        // Backpressure with a well-behaved source
        fork
            begin
                send_frame(3, BEATS, 1'b1);
                send_frame(4, BEATS, 1'b1);
                send_frame(5, BEATS, 1'b1);
                din_valid = 1'b0;
            end
            stall_window("bp");
        join
        wait_frames(6, 400);
        chk("bp_no_overflow", overflow, 1'b0);

        // Same traffic, source ignores din_ready
        ovf_first = 1'b0;
        fork
            begin
                send_frame(6, BEATS, 1'b0);
                send_frame(7, BEATS, 1'b0);
                send_frame(8, BEATS, 1'b0);
                din_valid = 1'b0;
            end
            stall_window("ovf");
        join
        chk("ovf_drop_seen", ovf_first, 1'b1);
        wait_frames(9, 400);
        chk("ovf_sticky", overflow, 1'b1);

        // Reset after input beat 17 of a partial frame
        send_frame(9, 18, 1'b1);
        din_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mrst_dout_valid", dout_valid, 1'b0);
        chk("mrst_dout_last", dout_last, 1'b0);
        chk("mrst_din_ready", din_ready, 1'b1);
        chk("mrst_overflow", overflow, 1'b0);
        chk("mrst_dout_re0", dout_re[0], 32'd0);
        chk("mrst_dout_im9", dout_im[9], 32'd0);
        rst = 1'b0;
        exp_q.delete();
        out_beat = 0;
        frames_out = 0;
        send_frame(10, BEATS, 1'b1);
        din_valid = 1'b0;
        wait_frames(1, 100);

        // Random frames with random downstream ready
        fork
            begin
                for (int f = 11; f < 19; f++) send_frame(f, BEATS, 1'b1);
                din_valid = 1'b0;
                wait_frames(9, 3000);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    dout_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                dout_ready = 1'b1;
            end
        join
        chk("rnd_no_overflow", overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
